// File: rtl/nn_host_sequencer_pkg.sv
// nn_host_sequencer_pkg: shared sizes, sequencer state encoding and config-word target decode
package nn_host_sequencer_pkg;
    localparam int WRITE_IN_BIT_WIDTH = 16;
    localparam int INPUT_LAYER_NODES = 6;
    localparam int L1_WEIGHT_WORDS = 6;
    localparam int L2_WEIGHT_WORDS = 4;
    localparam int ADDR_WIDTH = 10;
    localparam int NN_RESET_CYCLES = 2;
    localparam int PRED_TIMEOUT = 4096;
    localparam int CFG_WORDS = L1_WEIGHT_WORDS + L2_WEIGHT_WORDS + 2;

    typedef enum logic [2:0] {IDLE, CFG_WAIT, CFG_WRITE, NN_RST, COLLECT, STREAM, WAIT_PRED, HOLD} seqState_t;

    typedef struct packed {
        logic layer;
        logic isBias;
        logic [ADDR_WIDTH-1:0] addr;
    } cfgTarget_t;

    // word order: L1 weights, L1 bias, L2 weights, L2 bias; biases always sit at address 0
    function automatic cfgTarget_t cfgTarget(input int idx, input int l1Words, input int l2Words);
        cfgTarget_t t;
        t.layer = idx > l1Words;
        t.isBias = idx == l1Words || idx == l1Words + l2Words + 1;
        t.addr = idx < l1Words ? ADDR_WIDTH'(idx) : t.isBias ? '0 : ADDR_WIDTH'(idx - l1Words - 1);
        return t;
    endfunction
endpackage

// File: rtl/nn_host_sequencer_if.sv
// nn_host_sequencer_if: host-side configuration-word and pixel valid/ready streams
interface nn_host_sequencer_if
    import nn_host_sequencer_pkg::*;
();
    logic hostWordValid;
    logic [WRITE_IN_BIT_WIDTH-1:0] hostWord;
    logic hostWordReady;
    logic hostPixelValid;
    logic hostPixel;
    logic hostPixelReady;

    modport master(output hostWordValid, hostWord, hostPixelValid, hostPixel, input hostWordReady, hostPixelReady);
    modport slave(input hostWordValid, hostWord, hostPixelValid, hostPixel, output hostWordReady, hostPixelReady);
endinterface

// File: rtl/nn_pixel_buffer.sv
// nn_pixel_buffer: one-image bit buffer, filled from index 0 and drained in order
module nn_pixel_buffer #(
    parameter int DEPTH = 6
) (
    input  logic masterClk,
    input  logic reset,
    input  logic wrEn,
    input  logic wrData,
    input  logic rdEn,
    output logic rdData,
    output logic full,
    output logic empty,
    output logic rdLast
);
    localparam int IW = $clog2(DEPTH + 1);
    logic [DEPTH-1:0] pixels;
    logic [IW-1:0] wrIdx, rdIdx;

    assign full = wrIdx == IW'(DEPTH);
    assign empty = rdIdx == wrIdx;
    assign rdLast = rdIdx == IW'(DEPTH - 1);
    assign rdData = pixels[rdIdx];

    // fill and drain indices; reading the last pixel rewinds both so the next image starts clean
    always_ff @(posedge masterClk or negedge reset) begin
        if (!reset) begin
            pixels <= '0;
            wrIdx <= '0;
            rdIdx <= '0;
        end else if (rdEn && rdLast) begin
            wrIdx <= '0;
            rdIdx <= '0;
        end else begin
            if (wrEn && !full) begin
                pixels[wrIdx] <= wrData;
                wrIdx <= wrIdx + 1'b1;
            end
            if (rdEn && !empty) rdIdx <= rdIdx + 1'b1;
        end
    end
endmodule

// File: rtl/nn_host_sequencer.sv
// nn_host_sequencer: configures NN_Controler, pulses its reset, bursts one image and captures the prediction
module nn_host_sequencer
    import nn_host_sequencer_pkg::*;
(
    input  logic masterClk,
    input  logic reset,
    input  logic cfgStart,
    input  logic infStart,
    nn_host_sequencer_if.slave host,
    output logic nnReset,
    output logic weightWriteEnable,
    output logic biasWriteEnable,
    output logic LayerWriteSelect,
    output logic [ADDR_WIDTH-1:0] WriteAddressSelect,
    output logic [WRITE_IN_BIT_WIDTH-1:0] writeIn,
    output logic inputsInbound,
    output logic inputPixel,
    input  logic readyForInputs,
    input  logic predictionReady,
    input  logic [3:0] predictionOut,
    output logic predictionRecieved,
    output logic resultValid,
    output logic [3:0] resultOut,
    input  logic resultAck,
    output logic configured,
    output logic busy,
    output logic errorFlag
);
    localparam int WC_W = $clog2(CFG_WORDS + 1);
    localparam int RC_W = $clog2(NN_RESET_CYCLES + 1);
    localparam int PT_W = $clog2(PRED_TIMEOUT + 1);
    seqState_t state, nextState;
    logic [WC_W-1:0] wordCnt;
    logic [RC_W-1:0] rstCnt;
    logic [PT_W-1:0] predTimer;
    logic wordAccept, pixelAccept, streaming, pixFull, pixEmpty, pixLast, pixData;
    logic cfgLast, rstDone, timedOut, predCapture;
    cfgTarget_t target;

    assign host.hostWordReady = state == CFG_WAIT;
    assign host.hostPixelReady = state == COLLECT && !pixFull;
    assign wordAccept = host.hostWordReady && host.hostWordValid;
    assign pixelAccept = host.hostPixelReady && host.hostPixelValid;
    assign streaming = state == STREAM;
    assign cfgLast = wordCnt == WC_W'(CFG_WORDS - 1);
    assign rstDone = rstCnt == RC_W'(NN_RESET_CYCLES - 1);
    assign timedOut = predTimer == PT_W'(PRED_TIMEOUT - 1);
    assign predCapture = state == WAIT_PRED && predictionReady;
    assign target = cfgTarget(int'(wordCnt), L1_WEIGHT_WORDS, L2_WEIGHT_WORDS);
    assign nnReset = state == NN_RST;
    assign busy = state != IDLE;
    assign inputsInbound = streaming && !pixEmpty;
    assign inputPixel = inputsInbound && pixData;

    nn_pixel_buffer #(.DEPTH(INPUT_LAYER_NODES)) pixelBuffer (
        .masterClk(masterClk),
        .reset(reset),
        .wrEn(pixelAccept),
        .wrData(host.hostPixel),
        .rdEn(streaming),
        .rdData(pixData),
        .full(pixFull),
        .empty(pixEmpty),
        .rdLast(pixLast)
    );

    // state register
    always_ff @(posedge masterClk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= nextState;
    end

    // next state; cfgStart outranks infStart, and starts are only honoured in IDLE
    always_comb begin
        nextState = state;
        case (state)
            IDLE:      nextState = cfgStart ? CFG_WAIT : (infStart && configured) ? COLLECT : IDLE;
            CFG_WAIT:  nextState = wordAccept ? CFG_WRITE : CFG_WAIT;
            CFG_WRITE: nextState = cfgLast ? NN_RST : CFG_WAIT;
            NN_RST:    nextState = rstDone ? IDLE : NN_RST;
            COLLECT:   nextState = (pixFull && readyForInputs) ? STREAM : COLLECT;
            STREAM:    nextState = pixLast ? WAIT_PRED : STREAM;
            WAIT_PRED: nextState = predictionReady ? HOLD : timedOut ? IDLE : WAIT_PRED;
            HOLD:      nextState = resultAck ? IDLE : HOLD;
            default:   nextState = IDLE;
        endcase
    end

    // write strobes, counters, status flags and result capture
    always_ff @(posedge masterClk or negedge reset) begin
        if (!reset) begin
            weightWriteEnable <= 1'b0;
            biasWriteEnable <= 1'b0;
            LayerWriteSelect <= 1'b0;
            WriteAddressSelect <= '0;
            writeIn <= '0;
            wordCnt <= '0;
            rstCnt <= '0;
            predTimer <= '0;
            predictionRecieved <= 1'b0;
            resultValid <= 1'b0;
            resultOut <= '0;
            configured <= 1'b0;
            errorFlag <= 1'b0;
        end else begin
            weightWriteEnable <= wordAccept && !target.isBias;
            biasWriteEnable <= wordAccept && target.isBias;
            if (wordAccept) begin
                writeIn <= host.hostWord;
                LayerWriteSelect <= target.layer;
                WriteAddressSelect <= target.addr;
            end
            wordCnt <= state == CFG_WRITE ? (cfgLast ? '0 : wordCnt + 1'b1) : state == IDLE ? '0 : wordCnt;
            rstCnt <= nnReset ? rstCnt + 1'b1 : '0;
            predTimer <= state == WAIT_PRED ? predTimer + 1'b1 : '0;
            predictionRecieved <= predCapture;
            if (nnReset && rstDone) configured <= 1'b1;
            else if (state == IDLE && cfgStart) configured <= 1'b0;
            if (state == IDLE && cfgStart) errorFlag <= 1'b0;
            else if ((state == IDLE && infStart && !configured) || (state == WAIT_PRED && timedOut && !predictionReady)) errorFlag <= 1'b1;
            if (predCapture) begin
                resultOut <= predictionOut;
                resultValid <= 1'b1;
            end else if (state == HOLD && resultAck) resultValid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_nn_host_sequencer.sv
// tb_nn_host_sequencer: directed flow with random config words, pixels and predictions against a queue model
module tb_nn_host_sequencer;
    import nn_host_sequencer_pkg::*;

    typedef struct {
        int cycle;
        logic layer;
        logic bias;
        logic [ADDR_WIDTH-1:0] addr;
        logic [WRITE_IN_BIT_WIDTH-1:0] data;
    } wr_t;

    logic masterClk = 0, reset = 0, cfgStart = 0, infStart = 0;
    logic readyForInputs = 0, predictionReady = 0, resultAck = 0;
    logic [3:0] predictionOut = 0;
    logic nnReset, weightWriteEnable, biasWriteEnable, LayerWriteSelect, inputsInbound, inputPixel;
    logic predictionRecieved, resultValid, configured, busy, errorFlag;
    logic [ADDR_WIDTH-1:0] WriteAddressSelect;
    logic [WRITE_IN_BIT_WIDTH-1:0] writeIn;
    logic [3:0] resultOut;
    logic [WRITE_IN_BIT_WIDTH-1:0] words [CFG_WORDS];
    logic img [INPUT_LAYER_NODES];
    logic [3:0] pred;
    int checks = 0, failures = 0, cyc = 0, rstCycles = 0, recvPulses = 0, bothEn = 0, got;
    wr_t seenWr[$], expWr[$], w;
    int seenPix[$], pixCyc[$];

    nn_host_sequencer_if host();

    nn_host_sequencer dut (
        .masterClk(masterClk), .reset(reset), .cfgStart(cfgStart), .infStart(infStart), .host(host),
        .nnReset(nnReset), .weightWriteEnable(weightWriteEnable), .biasWriteEnable(biasWriteEnable),
        .LayerWriteSelect(LayerWriteSelect), .WriteAddressSelect(WriteAddressSelect), .writeIn(writeIn),
        .inputsInbound(inputsInbound), .inputPixel(inputPixel), .readyForInputs(readyForInputs),
        .predictionReady(predictionReady), .predictionOut(predictionOut), .predictionRecieved(predictionRecieved),
        .resultValid(resultValid), .resultOut(resultOut), .resultAck(resultAck),
        .configured(configured), .busy(busy), .errorFlag(errorFlag)
    );

    always #5 masterClk = ~masterClk;

    always @(posedge masterClk) cyc <= cyc + 1;

    // observe the controller-side traffic away from the active edge
    always @(negedge masterClk) begin
        wr_t m;
        if (weightWriteEnable || biasWriteEnable) begin
            m.cycle = cyc;
            m.layer = LayerWriteSelect;
            m.bias = biasWriteEnable;
            m.addr = WriteAddressSelect;
            m.data = writeIn;
            seenWr.push_back(m);
        end
        if (weightWriteEnable && biasWriteEnable) bothEn++;
        if (nnReset) rstCycles++;
        if (inputsInbound) begin
            seenPix.push_back(int'(inputPixel));
            pixCyc.push_back(cyc);
        end
        if (predictionRecieved) recvPulses++;
    end

    task automatic check(input string tag, input int obsV, input int expV);
        checks++;
        assert (obsV === expV) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obsV, expV);
        end
    endtask

    task automatic runImage(input bit holdReady);
        bit acc;
        seenPix.delete();
        pixCyc.delete();
        readyForInputs = !holdReady;
        @(negedge masterClk) infStart = 1;
        @(negedge masterClk) infStart = 0;
        got = 0;
        for (int c = 0; c < 100 && got < INPUT_LAYER_NODES; c++) begin
            host.hostPixelValid = holdReady ? (c % 2 == 0) : 1'($urandom_range(0, 1));
            host.hostPixel = img[got];
            acc = host.hostPixelValid && host.hostPixelReady;
            @(negedge masterClk);
            if (acc) got++;
        end
        host.hostPixelValid = 0;
        check("pix_accepted", got, INPUT_LAYER_NODES);
        if (holdReady) begin
            repeat (2) @(negedge masterClk);
            check("pix_ready_when_full", int'(host.hostPixelReady), 0);
            check("no_burst_without_ready", seenPix.size(), 0);
            cfgStart = 1;
            @(negedge masterClk) cfgStart = 0;
            check("cfg_ignored_when_busy", int'({busy, configured}), 3);
            readyForInputs = 1;
        end
        for (int c = 0; c < 40 && seenPix.size() < INPUT_LAYER_NODES; c++) @(negedge masterClk);
        readyForInputs = 0;
        check("burst_len", seenPix.size(), INPUT_LAYER_NODES);
        for (int k = 0; k < seenPix.size() && k < INPUT_LAYER_NODES; k++)
            check($sformatf("burst_pix%0d", k), seenPix[k], int'(img[k]));
        check("burst_contiguous", pixCyc[$] - pixCyc[0], INPUT_LAYER_NODES - 1);
        @(negedge masterClk);
        check("burst_ended", int'(inputsInbound), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        host.hostWordValid = 0;
        host.hostWord = 0;
        host.hostPixelValid = 0;
        host.hostPixel = 0;
        repeat (3) @(negedge masterClk);
        check("reset_flags", int'({nnReset, weightWriteEnable, biasWriteEnable, LayerWriteSelect, inputsInbound, inputPixel,
              predictionRecieved, resultValid, configured, busy, errorFlag, host.hostWordReady, host.hostPixelReady}), 0);
        check("reset_buses", int'(resultOut) + int'(WriteAddressSelect) + int'(writeIn), 0);
        reset = 1;
        @(negedge masterClk) infStart = 1;
        @(negedge masterClk) infStart = 0;
        check("inf_unconfigured_error", int'(errorFlag), 1);
        check("inf_unconfigured_busy", int'(busy), 0);
        cfgStart = 1;
        @(negedge masterClk) cfgStart = 0;
        check("cfg_clears_error", int'(errorFlag), 0);
        host.hostWordValid = 1;
        host.hostWord = WRITE_IN_BIT_WIDTH'($urandom);
        @(negedge masterClk) host.hostWordValid = 0;
        check("abort_strobe_before", int'(weightWriteEnable), 1);
        #1 reset = 0;
        #1;
        check("abort_strobe_dropped", int'(weightWriteEnable), 0);
        check("abort_idle", int'({configured, busy}), 0);
        @(negedge masterClk) reset = 1;
        seenWr.delete();
        for (int k = 0; k < CFG_WORDS; k++) words[k] = WRITE_IN_BIT_WIDTH'($urandom);
        for (int l = 0; l < 2; l++) begin
            for (int a = 0; a < (l == 0 ? L1_WEIGHT_WORDS : L2_WEIGHT_WORDS); a++) begin
                w.layer = 1'(l);
                w.bias = 0;
                w.addr = ADDR_WIDTH'(a);
                w.data = words[expWr.size()];
                expWr.push_back(w);
            end
            w.layer = 1'(l);
            w.bias = 1;
            w.addr = 0;
            w.data = words[expWr.size()];
            expWr.push_back(w);
        end
        @(negedge masterClk) cfgStart = 1;
        @(negedge masterClk) cfgStart = 0;
        got = 0;
        host.hostWordValid = 1;
        host.hostWord = words[0];
        for (int c = 0; c < 200 && got < CFG_WORDS; c++) begin
            acc = host.hostWordReady;
            @(negedge masterClk);
            if (acc) begin
                got++;
                if (got < CFG_WORDS) host.hostWord = words[got];
            end
        end
        host.hostWordValid = 0;
        check("cfg_words_accepted", got, CFG_WORDS);
        for (int c = 0; c < 20 && !configured; c++) @(negedge masterClk);
        check("configured", int'(configured), 1);
        check("cfg_write_count", seenWr.size(), CFG_WORDS);
        for (int k = 0; k < seenWr.size() && k < CFG_WORDS; k++) begin
            check($sformatf("wr%0d_layer", k), int'(seenWr[k].layer), int'(expWr[k].layer));
            check($sformatf("wr%0d_bias", k), int'(seenWr[k].bias), int'(expWr[k].bias));
            check($sformatf("wr%0d_addr", k), int'(seenWr[k].addr), int'(expWr[k].addr));
            check($sformatf("wr%0d_data", k), int'(seenWr[k].data), int'(expWr[k].data));
            if (k > 0) check($sformatf("wr%0d_spacing", k), seenWr[k].cycle - seenWr[k-1].cycle, 2);
        end
        check("both_enables", bothEn, 0);
        check("nn_reset_cycles", rstCycles, NN_RESET_CYCLES);
        check("cfg_done_idle", int'(busy), 0);
        img = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        runImage(1);
        predictionOut = 4'd7;
        predictionReady = 1;
        @(negedge masterClk) predictionReady = 0;
        check("pred_result", int'(resultOut), 7);
        check("pred_valid", int'(resultValid), 1);
        check("pred_ack_pulse", int'(predictionRecieved), 1);
        @(negedge masterClk);
        check("pred_ack_single", int'(predictionRecieved), 0);
        repeat (3) @(negedge masterClk);
        check("result_held", int'({resultValid, busy}), 3);
        resultAck = 1;
        @(negedge masterClk) resultAck = 0;
        check("result_released", int'({resultValid, busy}), 0);
        check("pred_ack_count", recvPulses, 1);
        for (int k = 0; k < INPUT_LAYER_NODES; k++) img[k] = 1'($urandom_range(0, 1));
        runImage(0);
        pred = 4'($urandom);
        predictionOut = pred;
        predictionReady = 1;
        resultAck = 1;
        @(negedge masterClk) predictionReady = 0;
        check("pred2_result", int'(resultOut), int'(pred));
        check("pred2_valid", int'(resultValid), 1);
        @(negedge masterClk) resultAck = 0;
        check("pred2_ack_on_entry", int'({resultValid, busy}), 0);
        check("pred2_ack_count", recvPulses, 2);
        for (int k = 0; k < INPUT_LAYER_NODES; k++) img[k] = 1'($urandom_range(0, 1));
        runImage(0);
        for (int c = 0; c < PRED_TIMEOUT + 100 && busy; c++) @(negedge masterClk);
        check("timeout_cycles", cyc - pixCyc[$], PRED_TIMEOUT + 1);
        check("timeout_error", int'(errorFlag), 1);
        check("timeout_no_result", int'(resultValid), 0);
        check("timeout_no_ack", recvPulses, 2);
        cfgStart = 1;
        @(negedge masterClk) cfgStart = 0;
        check("recfg_clears_error", int'(errorFlag), 0);
        check("recfg_clears_configured", int'(configured), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/nn_host_sequencer.md
Name: nn_host_sequencer

Overview:
Sequences the neural-network controller on behalf of a host. It takes host configuration words over a valid/ready stream and converts each into a single weight or bias write strobe for layer 1 then layer 2. It then pulses the controller reset, buffers one image of host pixels, and streams that image to the controller as one contiguous burst. Finally it waits for the prediction, captures it and acknowledges it. It sits between the host interface and NN_Controler.

Parameters:
INPUT_LAYER_NODES, 6, pixels per image (784 in production).
L1_WEIGHT_WORDS, 6, layer-1 weight words (addresses 0..N-1).
L2_WEIGHT_WORDS, 4, layer-2 weight words.
WRITE_IN_BIT_WIDTH, `WRITE_IN_BIT_WIDTH, config word width.
ADDR_WIDTH, 10, WriteAddressSelect width.
NN_RESET_CYCLES, 2, length of the controller reset pulse.
PRED_TIMEOUT, 4096, cycles allowed in WAIT_PRED before an error.

Ports:
masterClk  in  1  the single clock.
reset  in  1  asynchronous, active-low reset (the polarity and synchronicity are fixed).
cfgStart  in  1  one-cycle pulse that starts a configuration load.
infStart  in  1  one-cycle pulse that starts an inference.
hostWordValid  in  1  a configuration word is available.
hostWord  in  WRITE_IN_BIT_WIDTH  configuration word.
hostWordReady  out  1  the configuration word is accepted this cycle.
hostPixelValid  in  1  a pixel is available.
hostPixel  in  1  pixel value.
hostPixelReady  out  1  the pixel is accepted this cycle.
nnReset  out  1  active-high reset to NN_Controler.
weightWriteEnable, biasWriteEnable  out  1  each  write strobes.
LayerWriteSelect  out  1  layer select: 0 = layer 1, 1 = layer 2.
WriteAddressSelect  out  ADDR_WIDTH  node address.
writeIn  out  WRITE_IN_BIT_WIDTH  write data.
inputsInbound, inputPixel  out  1  each  pixel burst to the controller.
readyForInputs, predictionReady  in  1  each  controller status.
predictionOut  in  4  controller result.
predictionRecieved  out  1  one-cycle acknowledge to the controller.
resultValid  out  1  the captured result is held.
resultOut  out  4  captured result.
resultAck  in  1  host consumes the result.
configured  out  1  a full configuration has completed.
busy  out  1  sequencer is not in IDLE.
errorFlag  out  1  sticky error; cleared by cfgStart.

Behaviour:
- Reset (reset=0, asynchronous): all outputs are 0, the state is IDLE and all counters are 0.
  - Mid-operation reset: strobes drop immediately, configured=0, and any partial configuration or image is discarded.
- IDLE:
  - cfgStart goes to CFG_WAIT and clears errorFlag and configured.
  - infStart goes to COLLECT only if configured=1. If configured=0, the pulse is ignored and errorFlag is set.
  - Simultaneous cfgStart and infStart: cfgStart wins.
  - Starts received in any state other than IDLE are ignored.
- CFG_WAIT: hostWordReady=1.
  - On accept (valid&ready in cycle N), go to CFG_WRITE.
  - In cycle N+1, writeIn, LayerWriteSelect and WriteAddressSelect are registered and exactly one enable is high for one cycle; hostReady=0. Maximum rate is one word per 2 cycles.
  - Word order: L1 weights at addresses 0..L1_WEIGHT_WORDS-1 (layer 0, weight enable); L1 bias (layer 0, bias enable, address 0); L2 weights at addresses 0..L2_WEIGHT_WORDS-1 (layer 1); L2 bias (layer 1).
  - After the final bias write, go to NN_RST. Otherwise return to CFG_WAIT.
- NN_RST: nnReset=1 for exactly NN_RESET_CYCLES cycles, then configured=1 and the state returns to IDLE.
- COLLECT: hostPixelReady=1.
  - Accepted pixels fill the buffer at index 0 upward. The buffer holds exactly INPUT_LAYER_NODES pixels; hostPixelReady=0 once it is full.
  - When full and readyForInputs=1, go to STREAM.
- STREAM: inputsInbound=1 for exactly INPUT_LAYER_NODES consecutive cycles, with inputPixel equal to buffer index k in the k-th cycle. The burst never pauses; readyForInputs is sampled only at burst start. Then go to WAIT_PRED.
- WAIT_PRED:
  - On predictionReady=1, resultOut<=predictionOut, resultValid<=1, and predictionRecieved=1 for the next cycle only. Then go to HOLD.
  - If PRED_TIMEOUT cycles elapse first, set errorFlag and go to IDLE with no result.
- HOLD: resultValid stays at 1 until resultAck=1, then it clears and the state goes to IDLE. A resultAck coinciding with entry into HOLD is honoured on that cycle.
- busy = (state != IDLE).

Decomposition:
- State encodings and the config-word-count constant go in GlobalVariables.v, alongside WRITE_IN_BIT_WIDTH.
- One sub-module, nn_pixel_buffer: INPUT_LAYER_NODES-bit write-index fill, read-index drain, full/empty flags.

Test Plan:
- Reset during a CFG_WRITE cycle -> weightWriteEnable drops to 0 immediately and configured=0.
- cfgStart, then 12 words with hostWordValid held high -> six weight writes at addresses 0..5 on layer 0, a bias write on layer 0, four writes at addresses 0..3 on layer 1, a bias write on layer 1 → each enable is a single-cycle pulse spaced 2 cycles apart, then nnReset is high for 2 cycles and configured=1.
- infStart with configured=0 -> errorFlag=1, busy remains 0.
- After configuration, pixels 0,1,1,0,1,0 with hostPixelValid toggling, and readyForInputs=1 -> inputsInbound is high for exactly 6 cycles, carrying inputPixel 0,1,1,0,1,0 in order.
- predictionReady with predictionOut=7 -> resultOut=7 and resultValid=1, predictionRecieved pulses once, resultValid is held until resultAck.
- No predictionReady for 4096 cycles -> errorFlag=1 and the state returns to IDLE; a subsequent cfgStart clears errorFlag.
